// File: rtl/aes_iter_core_if.sv
// Handshake bundle for aes_iter_core.
//   master: block source / ciphertext sink side (drives in_valid/in_data/in_key/out_ready)
//   slave : the core (drives in_ready, out_valid, out_data, busy, round)
interface aes_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [3:0]   round;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy, round
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy, round
    );
endinterface

// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryption engine with valid/ready handshakes on both sides.
// FUSED=0 steps one transform (Add/Sub/Shift/Mix) per cycle; FUSED=1 a whole round per cycle.
// Ports:
//   clk_i   - clock, rising edge
//   reset_i - asynchronous active-high reset, discards any job in flight
//   bus_io  - aes_iter_core_if.slave: job input (in_*), ciphertext output (out_*), busy, round
module aes_iter_core #(
    parameter int unsigned ROUNDS = 10,
    parameter int unsigned FUSED  = 0
) (
    input logic            clk_i,
    input logic            reset_i,
    aes_iter_core_if.slave bus_io
);

    if (ROUNDS < 1 || ROUNDS > 10 || FUSED > 1) begin : g_param_check
        $error("aes_iter_core: ROUNDS must be 1..10 and FUSED must be 0 or 1");
    end

    localparam logic [3:0] LastRound = 4'(ROUNDS);

    typedef enum logic [2:0] {StIdle, StAdd, StSub, StShi, StMix, StDone} state_e;

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   round_q, round_d;

    // ---------------- AES helpers ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x240, inv;
        x2   = gmul(a, a);
        x3   = gmul(x2, a);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        inv  = gmul(gmul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
        return r;
    endfunction

    // Byte i sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3, row r is byte 4c+r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Round key r from round key r-1.
    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] rot, t, n0, n1, n2, n3;
        rot = {k[23:0], k[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
            ^ {rcon(r), 24'h0};
        n0  = k[127:96] ^ t;
        n1  = k[95:64] ^ n0;
        n2  = k[63:32] ^ n1;
        n3  = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // ---------------- datapath ----------------
    // In fused mode the transforms chain; otherwise each acts on the state register alone.
    logic [127:0] sb, sr, mc, k_next;
    logic         last;

    always_comb begin
        sb     = sub_bytes(st_q);
        sr     = shift_rows((FUSED != 0) ? sb : st_q);
        mc     = mix_columns((FUSED != 0) ? sr : st_q);
        k_next = expand_key(rk_q, round_q);
        last   = (round_q == LastRound);
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        round_d = round_q;
        case (state_q)
            StIdle: begin
                if (bus_io.in_valid) begin
                    st_d    = bus_io.in_data;
                    rk_d    = bus_io.in_key;
                    round_d = 4'd0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                if (FUSED != 0 && round_q != 4'd0) begin
                    st_d = (last ? sr : mc) ^ k_next;
                    rk_d = k_next;
                end else begin
                    st_d = st_q ^ rk_q;
                end
                if (last) begin
                    state_d = StDone;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = (FUSED != 0) ? StAdd : StSub;
                end
            end
            StSub: begin
                st_d    = sb;
                state_d = StShi;
            end
            StShi: begin
                st_d    = sr;
                rk_d    = k_next;
                state_d = last ? StAdd : StMix;
            end
            StMix: begin
                st_d    = mc;
                state_d = StAdd;
            end
            StDone: begin
                if (bus_io.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            st_q    <= '0;
            rk_q    <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            round_q <= round_d;
        end
    end

    assign bus_io.in_ready  = (state_q == StIdle);
    assign bus_io.out_valid = (state_q == StDone);
    assign bus_io.out_data  = st_q;
    assign bus_io.busy      = (state_q == StAdd) || (state_q == StSub)
                           || (state_q == StShi) || (state_q == StMix);
    assign bus_io.round     = round_q;

endmodule

// File: doc/aes_iter_core.md
# aes_iter_core

Iterative AES-128 encryption core with a valid/ready handshake on input and output, and a compile-time choice between one transform per cycle and one full round per cycle. It reuses the team's combinational helpers `addRoundKey`, `subBytes128`, `shift128`, `mixCol128` and `expandKey`. It sits between a block source (plaintext plus key) and a ciphertext sink, and replaces the free-running round sequencer with a restartable, back-pressured engine.

## Interface
- `ROUNDS`, default 10: number of AES rounds. Legal range 1..10; values outside it are a compile-time error.
- `FUSED`, default 0: datapath mode.
  - 0: one transform (Add, Sub, Shift or Mix) per cycle.
  - 1: one complete round per cycle.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_data`/`in_key` hold a valid job.
- `in_ready` out 1: core is idle and accepts a job.
- `in_data` in 128: plaintext block.
- `in_key` in 128: cipher key.
- `out_valid` out 1: `out_data` holds a finished ciphertext.
- `out_ready` in 1: sink accepts the ciphertext.
- `out_data` out 128: ciphertext.
- `busy` out 1: a job is in progress (states ADD..MIX).
- `round` out 4: current round index, 0..ROUNDS.

## Operation
- Registers:
  - `st` (128): state register.
  - `rk` (128): round-key register.
  - `round` (4): round counter.
  - FSM state: IDLE, ADD, SUB, SHI, MIX, DONE.
- Reset (asynchronous, any time): FSM=IDLE, `st`=0, `rk`=0, `round`=0.
  - Output values: `out_valid`=0, `busy`=0, `out_data`=0, `in_ready`=1.
  - An in-flight job is discarded and produces no output.
- `in_ready` = (FSM==IDLE). `in_valid` is ignored in every other state.
- Accept (IDLE, `in_valid` and `in_ready`): `st`<=`in_data`, `rk`<=`in_key`, `round`<=0, FSM<=ADD.
- FUSED=0 transitions:
  - ADD: `st`<=`st`^`rk`. If `round`==ROUNDS, FSM<=DONE; else `round`<=`round`+1 and FSM<=SUB.
  - SUB: `st`<=subBytes(`st`); FSM<=SHI.
  - SHI: `st`<=shiftRows(`st`) and `rk`<=expandKey(`rk`,`round`). FSM<=ADD if `round`==ROUNDS, else FSM<=MIX.
  - MIX: `st`<=mixColumns(`st`); FSM<=ADD.
- FUSED=1 (MIX and SHI unused):
  - ADD with `round`==0: `st`<=`st`^`rk`, `round`<=1, FSM stays ADD.
  - ADD with `round` in 1..ROUNDS-1: `k`=expandKey(`rk`,`round`); `st`<=mix(shift(sub(`st`)))^`k`; `rk`<=`k`; `round`++.
  - ADD with `round`==ROUNDS: same update without mix; FSM<=DONE.
- `expandKey(k,r)` produces round key r from round key r-1 using Rcon[r] (0x01,0x02,…,0x36).
- DONE: `out_valid`=1 and `out_data`=`st`.
  - On `out_ready`=1, FSM<=IDLE.
  - While `out_ready`=0, `out_data` and `out_valid` hold stable.
- `out_data` is driven from `st` in every state; it is meaningful only while `out_valid`=1.
- `busy` = FSM in {ADD, SUB, SHI, MIX}.

## Timing
- FUSED=0 latency: `out_valid` rises 4·ROUNDS clock edges after the accept edge.
  - 1 initial ADD, 4 edges for each of ROUNDS-1 middle rounds, 3 edges for the final round.
  - ROUNDS=10 gives 40.
- FUSED=1 latency: ROUNDS+1 edges after the accept edge; ROUNDS=10 gives 11.
- Handshake at DONE:
  - If `out_ready` is already high when DONE is entered, the output transfers in that cycle and `in_ready` rises on the next edge.
  - Minimum accept-to-accept period is latency+2 edges.
- No simultaneous accept and output: `in_ready` is low throughout DONE.
- `round` wraps only through a new accept or reset; it never exceeds ROUNDS.
- Reset asserted mid-job (any state): outputs reach reset values immediately, without waiting for a clock edge. The first edge after deassertion can accept a job.

## Test plan
- FIPS-197 App. B vector, FUSED=0, ROUNDS=10:
  - Stimulus: `in_data`=3243f6a8885a308d313198a2e0370734, `in_key`=2b7e151628aed2a6abf7158809cf4f3c, `out_ready`=1.
  - Response: `out_valid` exactly 40 edges after accept, `out_data`=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1 vector, FUSED=1:
  - Stimulus: `in_data`=00112233445566778899aabbccddeeff, `in_key`=000102030405060708090a0b0c0d0e0f.
  - Response: `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a after 11 edges.
- Back-pressure:
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid`.
  - Response: `out_data` stable; `in_ready`=0 and a concurrent `in_valid` is ignored. Raising `out_ready` gives one transfer, then `in_ready`=1.
- Reset mid-job:
  - Stimulus: assert `reset` in SHI of round 5.
  - Response: `busy`=0, `round`=0, `out_valid`=0 asynchronously. A new App. B job then completes correctly.
- ROUNDS=1, FUSED=0:
  - Response: `out_valid` after 4 edges; `out_data`=shift(sub(P^K))^expandKey(K,1), checked against the reference model.
- Back-to-back jobs: App. B followed immediately by App. C.1 with `out_ready`=1 produces both correct ciphertexts in order, accepts separated by 42 edges.
